intermediate_sig: RTL and testbench

- Small registered logic block that combines three single-bit inputs through one internal intermediate term: mid = in_1 AND in_2.
- Produces out_1 = mid AND in_3 and out_2 = mid OR in_3.
- Inputs pass through a configurable synchronizer; all outputs are registered.
- Used as a clean, clocked logic-combination stage between asynchronous control inputs and downstream logic.

---
 rtl/intermediate_sig.sv | 119 +++++++++++
 tb/tb_intermediate_sig.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/intermediate_sig.sv
// Synchronizes three async inputs, forms mid = in_1 & in_2 and registers mid/AND/OR results.
// Define INTERMEDIATE_SIG_CNT_EN to build the saturating out_1/out_2 assertion counters.
module intermediate_sig #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_1,
  input  logic               in_2,
  input  logic               in_3,
  input  logic               clr_cnt,
  output logic               out_1,
  output logic               out_2,
  output logic               mid_sig,
  output logic [COUNT_W-1:0] out_1_cnt,
  output logic [COUNT_W-1:0] out_2_cnt
);

  logic [2:0] in_vec;
  logic [2:0] sync_in;

  assign in_vec = {in_3, in_2, in_1};

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign sync_in = in_vec;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][2:0] sync_q;
      logic [SYNC_STAGES-1:0][2:0] sync_d;

      always_comb begin
        sync_d    = sync_q;
        sync_d[0] = in_vec;
        for (int i = 1; i < SYNC_STAGES; i++) begin
          sync_d[i] = sync_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q <= sync_d;
        end
      end

      assign sync_in = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic mid_d, mid_q;
  logic out_1_d, out_1_q;
  logic out_2_d, out_2_q;

  always_comb begin
    mid_d   = sync_in[0] & sync_in[1];
    out_1_d = mid_d & sync_in[2];
    out_2_d = mid_d | sync_in[2];
  end

  // All three outputs share one register stage so they change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mid_q   <= 1'b0;
      out_1_q <= 1'b0;
      out_2_q <= 1'b0;
    end else begin
      mid_q   <= mid_d;
      out_1_q <= out_1_d;
      out_2_q <= out_2_d;
    end
  end

  assign mid_sig = mid_q;
  assign out_1   = out_1_q;
  assign out_2   = out_2_q;

`ifdef INTERMEDIATE_SIG_CNT_EN
  logic [COUNT_W-1:0] out_1_cnt_d, out_1_cnt_q;
  logic [COUNT_W-1:0] out_2_cnt_d, out_2_cnt_q;

  // Clear wins over increment; counters stop at all-ones instead of wrapping.
  always_comb begin
    out_1_cnt_d = out_1_cnt_q;
    out_2_cnt_d = out_2_cnt_q;
    if (clr_cnt) begin
      out_1_cnt_d = '0;
      out_2_cnt_d = '0;
    end else begin
      if (out_1_q && (out_1_cnt_q != {COUNT_W{1'b1}})) begin
        out_1_cnt_d = out_1_cnt_q + 1'b1;
      end
      if (out_2_q && (out_2_cnt_q != {COUNT_W{1'b1}})) begin
        out_2_cnt_d = out_2_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_1_cnt_q <= '0;
      out_2_cnt_q <= '0;
    end else begin
      out_1_cnt_q <= out_1_cnt_d;
      out_2_cnt_q <= out_2_cnt_d;
    end
  end

  assign out_1_cnt = out_1_cnt_q;
  assign out_2_cnt = out_2_cnt_q;
`else
  logic unused_clr_cnt;
  assign unused_clr_cnt = clr_cnt;
  assign out_1_cnt      = '0;
  assign out_2_cnt      = '0;
`endif

endmodule

// File: tb/tb_intermediate_sig.sv
// Directed bench for intermediate_sig: default, zero-stage and 2-bit-counter instances share stimulus.
module tb_intermediate_sig;

`ifdef INTERMEDIATE_SIG_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_1 = 1'b0, in_2 = 1'b0, in_3 = 1'b0, clr_cnt = 1'b0;

  logic       a_o1, a_o2, a_m;
  logic [7:0] a_c1, a_c2;
  logic       z_o1, z_o2, z_m;
  logic [7:0] z_c1, z_c2;
  logic       s_o1, s_o2, s_m;
  logic [1:0] s_c1, s_c2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  intermediate_sig #(.SYNC_STAGES(2), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_1(in_1), .in_2(in_2), .in_3(in_3), .clr_cnt(clr_cnt),
    .out_1(a_o1), .out_2(a_o2), .mid_sig(a_m), .out_1_cnt(a_c1), .out_2_cnt(a_c2));

  intermediate_sig #(.SYNC_STAGES(0), .COUNT_W(8)) dut_ns (
    .clk(clk), .rst(rst), .in_1(in_1), .in_2(in_2), .in_3(in_3), .clr_cnt(clr_cnt),
    .out_1(z_o1), .out_2(z_o2), .mid_sig(z_m), .out_1_cnt(z_c1), .out_2_cnt(z_c2));

  intermediate_sig #(.SYNC_STAGES(2), .COUNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_1(in_1), .in_2(in_2), .in_3(in_3), .clr_cnt(clr_cnt),
    .out_1(s_o1), .out_2(s_o2), .mid_sig(s_m), .out_1_cnt(s_c1), .out_2_cnt(s_c2));

  typedef struct {
    logic a, b, c;
    logic o1, o2, m;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end else begin
      $display("ok   %s: %0d", name, actual);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic a, input logic b, input logic c);
    in_1 = a;
    in_2 = b;
    in_3 = c;
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    tick(1);
    clr_cnt = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{a:0, b:0, c:0, o1:0, o2:0, m:0};
    vecs[1] = '{a:0, b:1, c:0, o1:0, o2:0, m:0};
    vecs[2] = '{a:1, b:1, c:0, o1:0, o2:1, m:1};
    vecs[3] = '{a:0, b:1, c:1, o1:0, o2:1, m:0};
    vecs[4] = '{a:1, b:1, c:1, o1:1, o2:1, m:1};
    vecs[5] = '{a:0, b:0, c:1, o1:0, o2:1, m:0};
    vecs[6] = '{a:1, b:0, c:0, o1:0, o2:0, m:0};
    vecs[7] = '{a:1, b:0, c:1, o1:0, o2:1, m:0};

    tick(3);
    rst = 1'b0;

    // Asynchronous reset with 111 driven and outputs/counters active.
    set_in(1, 1, 1);
    tick(10);
    check("pre_reset_out_1", a_o1, 1);
    rst = 1'b1;
    #2;
    check("async_rst_out_1", a_o1, 0);
    check("async_rst_out_2", a_o2, 0);
    check("async_rst_mid", a_m, 0);
    check("async_rst_cnt1", a_c1, 0);
    check("async_rst_cnt2", a_c2, 0);
    check("async_rst_ns_out_2", z_o2, 0);
    tick(2);
    rst = 1'b0;

    // Release with inputs still 111: synchronizer refills, full latency applies.
    tick(1);
    check("post_rst_e1_out_1", a_o1, 0);
    check("post_rst_e1_ns_out_1", z_o1, 1);
    tick(1);
    check("post_rst_e2_out_1", a_o1, 0);
    tick(1);
    check("post_rst_e3_out_1", a_o1, 1);

    // Truth table sweep.
    for (int i = 0; i < 8; i++) begin
      set_in(vecs[i].a, vecs[i].b, vecs[i].c);
      tick(3);
      check($sformatf("tt%0d_out_1", i), a_o1, vecs[i].o1);
      check($sformatf("tt%0d_out_2", i), a_o2, vecs[i].o2);
      check($sformatf("tt%0d_mid", i), a_m, vecs[i].m);
      check($sformatf("tt%0d_ns_out_2", i), z_o2, vecs[i].o2);
      tick(7);
    end

    // Latency step 000 -> 111.
    set_in(0, 0, 0);
    tick(10);
    set_in(1, 1, 1);
    tick(1);
    check("lat_e1_out_1", a_o1, 0);
    check("lat_e1_ns_out_1", z_o1, 1);
    check("lat_e1_ns_mid", z_m, 1);
    tick(1);
    check("lat_e2_out_1", a_o1, 0);
    check("lat_e2_mid", a_m, 0);
    tick(1);
    check("lat_e3_out_1", a_o1, 1);
    check("lat_e3_out_2", a_o2, 1);
    check("lat_e3_mid", a_m, 1);

    // Counters: clear, count 20 edges with 111 settled, clear again.
    pulse_clr();
    check("clr_cnt1", a_c1, 0);
    check("clr_cnt2", a_c2, 0);
    tick(20);
    check("cnt1_20", a_c1, CNT_EN ? 20 : 0);
    check("cnt2_20", a_c2, CNT_EN ? 20 : 0);
    check("sat_cnt1_full", s_c1, CNT_EN ? 3 : 0);
    clr_cnt = 1'b1;
    tick(1);
    check("clr_prio_cnt1", a_c1, 0);
    check("clr_prio_cnt2", a_c2, 0);
    check("clr_hold_sat_cnt1", s_c1, 0);
    tick(1);
    check("clr_held_cnt1", a_c1, 0);
    clr_cnt = 1'b0;
    tick(1);
    check("after_clr_cnt1", a_c1, CNT_EN ? 1 : 0);

    // Saturation with COUNT_W=2 on pattern 011.
    set_in(0, 1, 1);
    tick(10);
    pulse_clr();
    tick(2);
    check("sat_cnt2_2", s_c2, CNT_EN ? 2 : 0);
    tick(1);
    check("sat_cnt2_3", s_c2, CNT_EN ? 3 : 0);
    tick(7);
    check("sat_cnt2_stuck", s_c2, CNT_EN ? 3 : 0);
    check("sat_cnt1_zero", s_c1, 0);
    check("sat_out_2", s_o2, 1);
    check("sat_out_1", s_o1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
